// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO in front of a UART transmitter. Each byte is popped
// into tx_data and held there for the whole frame, started with a one-cycle
// tx_start pulse, and released when the transmitter pulses tx_ok.
// Optional feature macro: UART_TX_FEEDER_GAP_EN adds GAP_CYCLES idle cycles
// after every frame.
module uart_tx_feeder #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  input  logic                  tx_ok
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FullCount = (DEPTH_LOG2 + 1)'(Depth);

`ifdef UART_TX_FEEDER_GAP_EN
  typedef enum logic [1:0] {StIdle, StStart, StWaitOk, StGap} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StWaitOk} state_e;
`endif

  state_e                state_q, state_d;
  logic [7:0]            mem [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q;
  logic [7:0]            tx_data_q;
  logic                  pop;
  logic                  wr_accept;
  logic                  wr_drop;
`ifdef UART_TX_FEEDER_GAP_EN
  logic [7:0]            gap_cnt_q;
`endif

  assign full      = (count_q == FullCount);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign tx_data   = tx_data_q;
  // A same-cycle pop never frees room for a write while full.
  assign wr_accept = wr_en && !full && !flush;
  assign wr_drop   = wr_en && full && !flush;

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Drain FSM next state, pop decision and start pulse.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    tx_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !tx_busy) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_start = 1'b1;
        state_d  = StWaitOk;
      end
      StWaitOk: begin
`ifdef UART_TX_FEEDER_GAP_EN
        if (tx_ok) state_d = StGap;
`else
        if (tx_ok) state_d = StIdle;
`endif
      end
`ifdef UART_TX_FEEDER_GAP_EN
      StGap: begin
        if (gap_cnt_q == 8'(GAP_CYCLES - 1)) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Occupancy next value; flush wins over any write or pop.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (wr_accept && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr_accept && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q] <= wr_data;
  end

  // Pointers, count, overflow pulse and the held transmit byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      count_q    <= count_d;
      overflow_q <= wr_drop;
      // A pop coinciding with flush still launches its byte; the frame is kept.
      if (pop) tx_data_q <= mem[rd_ptr_q];
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

`ifdef UART_TX_FEEDER_GAP_EN
  // Gap counter: counts cycles spent in StGap, cleared everywhere else.
  always_ff @(posedge clk) begin
    if (!rst_n || state_q != StGap) gap_cnt_q <= 8'd0;
    else                            gap_cnt_q <= gap_cnt_q + 8'd1;
  end
`endif

endmodule
